order_book_deadlock_report_ctrl: RTL and testbench

Supervisory controller that sits above the per-instance HLS deadlock monitors of the order_book design. It qualifies their raw block flags with a persistence threshold and arbitrates among simultaneously blocked monitors. It latches a snapshot of the winning monitor's AXIS block signals and delivers one report record over a valid/ready handshake to the debug logger. After delivery it holds a sticky deadlock flag until software clears it.

---
 rtl/order_book_deadlock_report_ctrl_pkg.sv | 31 +++
 rtl/order_book_prio_enc.sv | 25 ++
 rtl/order_book_deadlock_report_ctrl.sv | 169 ++++++++++++++++
 tb/tb_order_book_deadlock_report_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/order_book_deadlock_report_ctrl_pkg.sv
// Shared definitions for the order_book deadlock report controller.
// Contents:
//   - 3-bit state encodings and the FSM state type
//   - report record field widths (monitor index, persistence counter)
//   - false-alarm counter width and its saturating increment helper
package order_book_deadlock_report_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WATCH   = 3'd1;
  localparam logic [2:0] ST_CONFIRM = 3'd2;
  localparam logic [2:0] ST_REPORT  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WATCH   = ST_WATCH,
    CONFIRM = ST_CONFIRM,
    REPORT  = ST_REPORT,
    HOLD    = ST_HOLD
  } state_t;

  localparam int IDX_W = 4;   // monitor index field of the report record
  localparam int CNT_W = 16;  // persistence counter width
  localparam int FA_W  = 8;   // false-alarm counter width

  // Increment that sticks at all-ones.
  function automatic logic [FA_W-1:0] sat_inc(input logic [FA_W-1:0] v);
    return (&v) ? v : v + FA_W'(1);
  endfunction

endpackage

// File: rtl/order_book_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec  in  NUM_MON  request vector, bit 0 has highest priority
//   idx  out 4        index of the lowest set bit (0 when none set)
//   any  out 1        at least one bit of vec is set
module order_book_prio_enc
  import order_book_deadlock_report_ctrl_pkg::*;
#(
  parameter int NUM_MON = 4
) (
  input  logic [NUM_MON-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/order_book_deadlock_report_ctrl.sv
// Supervisory deadlock report controller for the order_book HLS monitors.
// Qualifies raw monitor block flags with a persistence threshold, picks the
// lowest-index blocked monitor, snapshots its AXIS block bits plus a
// timestamp, and delivers one report record to the debug logger. A sticky
// deadlock flag is then held until software pulses clear.
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous active-low reset
//   enable           in   arms detection; low aborts WATCH/CONFIRM to IDLE
//   clear            in   pulse; releases HOLD, zeroes false-alarm count
//                         when seen in IDLE/WATCH/CONFIRM
//   block_in         in   per-monitor block flags
//   axis_sigs_in     in   per-monitor AXIS block bits, AXIS_W per monitor
//   rpt_valid        out  report record valid
//   rpt_ready        in   logger accepts record
//   rpt_idx          out  confirmed monitor index
//   rpt_axis         out  AXIS snapshot of rpt_idx at confirmation
//   rpt_ts           out  timestamp at confirmation
//   deadlock_flag    out  sticky flag, high in REPORT and HOLD
//   false_alarm_cnt  out  saturating count of aborted candidates
//   fsm_state        out  current state encoding, for observation
//
// Report handshake: the record transfers on a clock edge where rpt_valid
// and rpt_ready are both high. Once rpt_valid rises, it and every record
// field stay constant until that transfer edge; rpt_ready may be high at
// any time, including before rpt_valid.
module order_book_deadlock_report_ctrl
  import order_book_deadlock_report_ctrl_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int AXIS_W  = 7,
  parameter int THRESH  = 16,
  parameter int TS_W    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [NUM_MON-1:0]        block_in,
  input  logic [NUM_MON*AXIS_W-1:0] axis_sigs_in,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [IDX_W-1:0]          rpt_idx,
  output logic [AXIS_W-1:0]         rpt_axis,
  output logic [TS_W-1:0]           rpt_ts,
  output logic                      deadlock_flag,
  output logic [FA_W-1:0]           false_alarm_cnt,
  output logic [2:0]                fsm_state
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          cand;
  logic [TS_W-1:0]           ts;

  logic [IDX_W-1:0]          enc_idx;
  logic                      enc_any;
  logic [15:0]               blk_ext;
  logic                      cand_blk;
  logic [NUM_MON*AXIS_W-1:0] axis_sh;
  logic [AXIS_W-1:0]         cand_axis;
  logic [CNT_W-1:0]          cnt_next;

  order_book_prio_enc #(.NUM_MON(NUM_MON)) u_prio_enc (
    .vec (block_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Widen block_in to the full 4-bit index range so the candidate index
  // never selects outside the vector.
  always_comb begin
    blk_ext   = 16'(block_in);
    cand_blk  = blk_ext[cand];
    axis_sh   = axis_sigs_in >> (int'(cand) * AXIS_W);
    cand_axis = axis_sh[AXIS_W-1:0];
    cnt_next  = cnt + CNT_W'(1);
  end

  assign fsm_state = state;

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      cand            <= '0;
      rpt_valid       <= 1'b0;
      rpt_idx         <= '0;
      rpt_axis        <= '0;
      rpt_ts          <= '0;
      deadlock_flag   <= 1'b0;
      false_alarm_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear)  false_alarm_cnt <= '0;
          if (enable) state <= WATCH;
        end

        WATCH: begin
          if (clear) false_alarm_cnt <= '0;
          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (enc_any) begin
            cand  <= enc_idx;
            cnt   <= CNT_W'(1);
            state <= CONFIRM;
          end
        end

        CONFIRM: begin
          // clear wins over a coincident false alarm.
          if (clear)
            false_alarm_cnt <= '0;
          else if (enable && !cand_blk)
            false_alarm_cnt <= sat_inc(false_alarm_cnt);

          if (!enable) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!cand_blk) begin
            state <= WATCH;
            cnt   <= '0;
          end else if (cnt_next == THRESH_C) begin
            // cnt already counts earlier samples; this edge is sample THRESH.
            rpt_idx       <= cand;
            rpt_axis      <= cand_axis;
            rpt_ts        <= ts;
            rpt_valid     <= 1'b1;
            deadlock_flag <= 1'b1;
            cnt           <= '0;
            state         <= REPORT;
          end else begin
            cnt <= cnt_next;
          end
        end

        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (clear) begin
            deadlock_flag <= 1'b0;
            state         <= enable ? WATCH : IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_book_deadlock_report_ctrl.sv
// Directed bench for order_book_deadlock_report_ctrl (NUM_MON=4, THRESH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point. cyc mirrors the DUT timestamp: edges since reset release.
module tb_order_book_deadlock_report_ctrl;
  import order_book_deadlock_report_ctrl_pkg::*;

  localparam int NUM_MON = 4;
  localparam int AXIS_W  = 7;
  localparam int THRESH  = 4;
  localparam int TS_W    = 32;

  logic                      clock;
  logic                      reset;
  logic                      enable;
  logic                      clear;
  logic [NUM_MON-1:0]        block_in;
  logic [NUM_MON*AXIS_W-1:0] axis_sigs_in;
  logic                      rpt_valid;
  logic                      rpt_ready;
  logic [3:0]                rpt_idx;
  logic [AXIS_W-1:0]         rpt_axis;
  logic [TS_W-1:0]           rpt_ts;
  logic                      deadlock_flag;
  logic [7:0]                false_alarm_cnt;
  logic [2:0]                fsm_state;

  int checks;
  int failures;
  int cyc;
  int s;
  logic saw_valid;

  order_book_deadlock_report_ctrl #(
    .NUM_MON (NUM_MON),
    .AXIS_W  (AXIS_W),
    .THRESH  (THRESH),
    .TS_W    (TS_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear           (clear),
    .block_in        (block_in),
    .axis_sigs_in    (axis_sigs_in),
    .rpt_valid       (rpt_valid),
    .rpt_ready       (rpt_ready),
    .rpt_idx         (rpt_idx),
    .rpt_axis        (rpt_axis),
    .rpt_ts          (rpt_ts),
    .deadlock_flag   (deadlock_flag),
    .false_alarm_cnt (false_alarm_cnt),
    .fsm_state       (fsm_state)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    s            = 0;
    saw_valid    = 1'b0;
    reset        = 1'b0;
    enable       = 1'b0;
    clear        = 1'b0;
    block_in     = '0;
    rpt_ready    = 1'b0;
    // slice3=55, slice2=21, slice1=0C, slice0=33
    axis_sigs_in = {7'h55, 7'h21, 7'h0C, 7'h33};

    // Reset state
    #2;
    check("rst_valid", rpt_valid, 0);
    check("rst_flag", deadlock_flag, 0);
    check("rst_ts", rpt_ts, 0);
    check("rst_idx", rpt_idx, 0);
    check("rst_axis", rpt_axis, 0);
    check("rst_fa", false_alarm_cnt, 0);
    check("rst_state", fsm_state, ST_IDLE);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = 0;

    // Test 1: monitor 2 blocked from cycle 10, report at cycle 14
    enable = 1'b1;
    step();
    check("t1_watch", fsm_state, ST_WATCH);
    while (cyc < 10) step();
    block_in = 4'b0100;
    repeat (3) step();
    check("t1_confirm", fsm_state, ST_CONFIRM);
    check("t1_no_valid_yet", rpt_valid, 0);
    step();
    check("t1_cycle", cyc, 14);
    check("t1_valid", rpt_valid, 1);
    check("t1_idx", rpt_idx, 2);
    check("t1_axis", rpt_axis, 7'h21);
    check("t1_ts", rpt_ts, 13);
    check("t1_flag", deadlock_flag, 1);
    rpt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_hold_valid", rpt_valid, 1);
      check("t1_hold_idx", rpt_idx, 2);
      check("t1_hold_axis", rpt_axis, 7'h21);
      check("t1_hold_ts", rpt_ts, 13);
    end
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    block_in  = '0;
    check("t1_hold_state", fsm_state, ST_HOLD);
    check("t1_hold_valid0", rpt_valid, 0);
    check("t1_hold_flag", deadlock_flag, 1);
    check("t1_hold_fields", {rpt_idx, rpt_axis, rpt_ts}, {4'd2, 7'h21, 32'd13});

    // Test 4: clear in HOLD with enable low goes to IDLE
    enable = 1'b0;
    clear  = 1'b1;
    step();
    clear = 1'b0;
    check("t4_idle", fsm_state, ST_IDLE);
    check("t4_flag", deadlock_flag, 0);
    enable = 1'b1;
    step();
    check("t4_watch", fsm_state, ST_WATCH);

    // Test 2: 3-cycle glitch on monitor 1 is a false alarm
    block_in = 4'b0010;
    repeat (3) step();
    block_in = '0;
    step();
    check("t2_state", fsm_state, ST_WATCH);
    check("t2_fa1", false_alarm_cnt, 1);
    check("t2_no_valid", rpt_valid, 0);
    for (int i = 1; i < 300; i++) begin
      block_in = 4'b0010;
      repeat (3) begin
        step();
        if (rpt_valid) saw_valid = 1'b1;
      end
      block_in = '0;
      step();
      if (rpt_valid) saw_valid = 1'b1;
    end
    check("t2_fa_sat", false_alarm_cnt, 255);
    check("t2_never_valid", saw_valid, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t2_clear_fa", false_alarm_cnt, 0);
    check("t2_clear_state", fsm_state, ST_WATCH);

    // Test 3a: simultaneous 1010 picks monitor 1
    block_in = 4'b1010;
    s = cyc;
    repeat (3) step();
    check("t3_confirm", fsm_state, ST_CONFIRM);
    step();
    check("t3_valid", rpt_valid, 1);
    check("t3_idx", rpt_idx, 1);
    check("t3_axis", rpt_axis, 7'h0C);
    check("t3_ts", rpt_ts, s + 3);

    // Test 5b: clear and enable changes are ignored in REPORT
    clear  = 1'b1;
    enable = 1'b0;
    repeat (2) step();
    check("t5_rpt_state", fsm_state, ST_REPORT);
    check("t5_rpt_valid", rpt_valid, 1);
    clear     = 1'b0;
    enable    = 1'b1;
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    check("t3_hold", fsm_state, ST_HOLD);

    // Clear with block_in already high in HOLD: WATCH first, then CONFIRM
    block_in = 4'b1010;
    clear    = 1'b1;
    step();
    clear = 1'b0;
    check("t3_clear_watch", fsm_state, ST_WATCH);
    step();
    check("t3_next_confirm", fsm_state, ST_CONFIRM);

    // Test 3b: bit 1 drops, bit 3 stays high -> fresh candidate 3
    step();
    block_in = 4'b1000;
    step();
    check("t3_fa_state", fsm_state, ST_WATCH);
    check("t3_fa_cnt", false_alarm_cnt, 1);
    check("t3_fa_no_valid", rpt_valid, 0);
    s = cyc;
    repeat (3) step();
    check("t3b_confirm", fsm_state, ST_CONFIRM);
    check("t3b_no_valid", rpt_valid, 0);
    step();
    check("t3b_valid", rpt_valid, 1);
    check("t3b_idx", rpt_idx, 3);
    check("t3b_axis", rpt_axis, 7'h55);
    check("t3b_ts", rpt_ts, s + 3);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    block_in  = '0;
    clear     = 1'b1;
    step();
    clear = 1'b0;
    check("t3b_back_watch", fsm_state, ST_WATCH);

    // Test 5: enable drops with cnt=3, no false alarm counted
    block_in = 4'b0001;
    repeat (3) step();
    check("t5_confirm", fsm_state, ST_CONFIRM);
    enable = 1'b0;
    step();
    check("t5_idle", fsm_state, ST_IDLE);
    check("t5_fa_same", false_alarm_cnt, 1);
    check("t5_no_valid", rpt_valid, 0);
    block_in = '0;
    step();
    check("t5_stay_idle", fsm_state, ST_IDLE);

    // Test 6: asynchronous reset in the middle of REPORT
    enable = 1'b1;
    step();
    block_in = 4'b0100;
    repeat (4) step();
    check("t6_report", rpt_valid, 1);
    check("t6_flag_pre", deadlock_flag, 1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_async_valid", rpt_valid, 0);
    check("t6_async_flag", deadlock_flag, 0);
    check("t6_async_ts", rpt_ts, 0);
    check("t6_async_state", fsm_state, ST_IDLE);
    enable   = 1'b0;
    block_in = '0;
    step();
    reset = 1'b1;
    cyc   = 0;
    check("t6_release_state", fsm_state, ST_IDLE);
    step();
    check("t6_after_edge", fsm_state, ST_IDLE);
    check("t6_fa_reset", false_alarm_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
